pga_gain_ctrl: RTL
==================

// Module: pga_gain_ctrl
// PURPOSE
//  Parametrised gain-select controller for N_CH latched-input PGAs sharing one address bus (A_out)
//  with a per-channel write strobe (WR_out[i]). Mirrors the gain_in word of each channel into its PGA.
//  Writes only on change, serviced round-robin, with programmable setup/strobe/hold timing.
//  Sits between the servo register file (gain_in) and the analog front-end pins.
// PARAMETERS
//  N_CH        2    number of PGA channels (1..16)
//  GAIN_W      2    address/gain bits per channel (1..4)
//  CLK_DIV     25   clk_in cycles per FSM tick (>=2); 25 gives a 2 MHz tick from 50 MHz
//  RST_TICKS   255  ticks spent in RST after reset, letting the PGAs power up (>=1)
//  SETUP_TICKS 1    ticks A_out is stable before WR rises (>=1)
//  WR_TICKS    1    ticks WR is high (>=1)
//  HOLD_TICKS  1    ticks A_out is held after WR falls (>=1)
//  REFRESH_TICKS 65535  ticks between forced rewrites (used only with PGA_REFRESH_EN)
// PORTS
//  clk_in      in   1             system clock; only clock in the block
//  rst_in      in   1             synchronous active-high reset
//  gain_in     in   N_CH*GAIN_W   requested gain; channel i = [i*GAIN_W +: GAIN_W]
//  A_out       out  GAIN_W        shared PGA address bus
//  WR_out      out  N_CH          per-channel write strobe, active high
//  busy_out    out  1             high while the FSM is in any state other than IDLE
//  applied_out out  N_CH*GAIN_W   last gain written to each channel (0 until written)
//  valid_out   out  N_CH          bit i set once channel i has been written since reset or refresh
// BEHAVIOUR
//  - Tick: tick_cnt counts 0..CLK_DIV-1. tick pulses for one clk_in cycle when tick_cnt == CLK_DIV-1.
//    The FSM and all outputs update only on tick cycles. No derived clocks.
//  - Reset (sync, on any edge with rst_in=1, including mid-write):
//    tick_cnt=0; state=RST; A_out=0; WR_out=0; busy_out=1; applied_out=0; valid_out=0; rr_ptr=0.
//  - RST: stays for RST_TICKS ticks, then goes to IDLE.
//  - IDLE: A_out=0, WR_out=0, busy_out=0. On each tick, find the pending channels.
//    Channel i is pending when valid_out[i]==0 or gain_in[i] != applied_out[i].
//    Scan starts at rr_ptr and wraps at N_CH-1 to 0; the first pending channel c is selected.
//    On the same edge: latch g=gain_in[c], A_out<=g, busy_out<=1, enter SETUP.
//    If no channel is pending, remain in IDLE.
//  - SETUP (SETUP_TICKS ticks) -> STROBE: on entry to STROBE, WR_out[c]<=1.
//  - STROBE (WR_TICKS ticks) -> HOLD: on entry to HOLD, WR_out[c]<=0.
//    On the same edge: applied_out[c]<=g, valid_out[c]<=1.
//  - HOLD (HOLD_TICKS ticks) -> IDLE: on entry to IDLE, A_out<=0 and rr_ptr<=(c+1) mod N_CH.
//  - One write therefore takes SETUP+WR+HOLD ticks; IDLE re-evaluates 1 tick later.
//    Changing gain_in during a write does not disturb the write in progress (g is latched).
//    The new value is picked up on a later IDLE scan. At most one WR_out bit is ever high.
//  - Back-to-back changes on all channels are serviced in round-robin order, so no channel starves.
//  - Worst-case latency from a gain_in change to its WR rise is
//    N_CH*(SETUP+WR+HOLD+1) ticks + CLK_DIV cycles.
//  - Illegal state encoding: go to IDLE with WR_out=0.
// CONFIGURATION
//  PGA_REFRESH_EN defined: a refresh counter counts ticks while not in RST.
//    At REFRESH_TICKS-1 it clears valid_out (all bits) and wraps to 0.
//    If a write is in progress, the clear happens first and the HOLD-entry set of valid_out[c]
//    then applies, so c is not rewritten twice. All other channels are then rewritten on
//    subsequent IDLE scans, which guards against PGA upsets.
//  PGA_REFRESH_EN undefined: no refresh counter; REFRESH_TICKS is ignored.
//    Channels are written only after reset or on a gain change.
// TESTING (bench: N_CH=4, GAIN_W=2, CLK_DIV=4, RST_TICKS=3, SETUP/WR/HOLD_TICKS=1/2/1)
//  1. Reset with gain_in=8'hE4 -> after 3 RST ticks, writes ch0..3 in order with A_out=0,1,2,3.
//     Each WR is high for exactly 8 clk_in cycles; then valid_out=4'hF and applied_out=8'hE4.
//  2. Idle, ch2 gain 2->1 -> single write: A_out=1, only WR_out[2] pulses.
//     WR rises 1 tick after the IDLE tick that detects the change; applied_out[5:4]=1.
//  3. Change ch1 during ch1's STROBE -> the first write completes with the old value;
//     a second ch1 write with the new value follows.
//  4. All four channels change at once while rr_ptr=2 -> service order is 2,3,0,1.
//     At most one WR_out bit is high in any cycle.
//  5. Assert rst_in for 1 cycle during STROBE -> the next edge gives WR_out=0, A_out=0,
//     valid_out=0, busy_out=1; full power-up rewrite follows.
//  6. PGA_REFRESH_EN, REFRESH_TICKS=64, gain_in static -> all 4 channels are rewritten every
//     64 ticks. With the macro undefined, no WR activity occurs after the initial writes.

Source files
------------

// File: rtl/pga_gain_ctrl.sv
// Round-robin gain writer for N_CH latched PGAs sharing one address bus, with per-channel strobes.
// Optional PGA_REFRESH_EN periodically invalidates every channel so all PGAs are rewritten.
module pga_gain_ctrl #(
    parameter int N_CH          = 2,
    parameter int GAIN_W        = 2,
    parameter int CLK_DIV       = 25,
    parameter int RST_TICKS     = 255,
    parameter int SETUP_TICKS   = 1,
    parameter int WR_TICKS      = 1,
    parameter int HOLD_TICKS    = 1,
    parameter int REFRESH_TICKS = 65535
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [N_CH*GAIN_W-1:0]   gain_in,
    output logic [GAIN_W-1:0]        A_out,
    output logic [N_CH-1:0]          WR_out,
    output logic                     busy_out,
    output logic [N_CH*GAIN_W-1:0]   applied_out,
    output logic [N_CH-1:0]          valid_out
);
    localparam int TW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int M1   = (RST_TICKS > SETUP_TICKS) ? RST_TICKS : SETUP_TICKS;
    localparam int M2   = (WR_TICKS > HOLD_TICKS) ? WR_TICKS : HOLD_TICKS;
    localparam int PMAX = (M1 > M2) ? M1 : M2;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_IDLE   = 3'd1,
        S_SETUP  = 3'd2,
        S_STROBE = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t                    state, state_nxt;
    logic [TW-1:0]             tick_cnt;
    logic                      tick;
    logic [PW-1:0]             phase, phase_nxt, dur_m1;
    logic [CW-1:0]             rr_ptr, rr_nxt, sel, sel_nxt, pend_ch;
    logic [GAIN_W-1:0]         gain_lat, gain_lat_nxt, a_nxt;
    logic [N_CH-1:0]           wr_nxt, valid_nxt, pending, pend_rot;
    logic [2*N_CH-1:0]         pend_dbl;
    logic [N_CH*GAIN_W-1:0]    applied_nxt;
    logic                      pend_found, refresh_hit;
    int                        ch_sum;

    assign tick = (tick_cnt == TW'(CLK_DIV - 1));

`ifdef PGA_REFRESH_EN
    localparam int RW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
    logic [RW-1:0] refresh_cnt;

    assign refresh_hit = tick && (state != S_RST) && (refresh_cnt == RW'(REFRESH_TICKS - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in)
            refresh_cnt <= '0;
        else if (tick && (state != S_RST))
            refresh_cnt <= refresh_hit ? '0 : refresh_cnt + 1'b1;
    end
`else
    assign refresh_hit = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tick_cnt    <= '0;
            state       <= S_RST;
            phase       <= '0;
            A_out       <= '0;
            WR_out      <= '0;
            applied_out <= '0;
            valid_out   <= '0;
            rr_ptr      <= '0;
            sel         <= '0;
            gain_lat    <= '0;
        end else begin
            tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
            state       <= state_nxt;
            phase       <= phase_nxt;
            A_out       <= a_nxt;
            WR_out      <= wr_nxt;
            applied_out <= applied_nxt;
            valid_out   <= valid_nxt;
            rr_ptr      <= rr_nxt;
            sel         <= sel_nxt;
            gain_lat    <= gain_lat_nxt;
        end
    end

    // Rotate the pending vector so bit 0 is the round-robin start, then take the first set bit.
    always_comb begin
        pending    = '0;
        pend_found = 1'b0;
        pend_ch    = '0;
        ch_sum     = 0;
        for (int i = 0; i < N_CH; i++)
            pending[i] = !valid_out[i] ||
                         (gain_in[i*GAIN_W +: GAIN_W] != applied_out[i*GAIN_W +: GAIN_W]);
        pend_dbl = {pending, pending} >> rr_ptr;
        pend_rot = pend_dbl[N_CH-1:0];
        for (int k = 0; k < N_CH; k++) begin
            if (!pend_found && pend_rot[k]) begin
                pend_found = 1'b1;
                ch_sum     = int'(rr_ptr) + k;
                if (ch_sum >= N_CH)
                    ch_sum = ch_sum - N_CH;
                pend_ch    = CW'(ch_sum);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        case (state)
            S_RST:    dur_m1 = PW'(RST_TICKS - 1);
            S_SETUP:  dur_m1 = PW'(SETUP_TICKS - 1);
            S_STROBE: dur_m1 = PW'(WR_TICKS - 1);
            S_HOLD:   dur_m1 = PW'(HOLD_TICKS - 1);
            default:  dur_m1 = '0;
        endcase
        if (tick)
            phase_nxt = phase + 1'b1;
        case (state)
            S_RST:    if (tick && phase == dur_m1) state_nxt = S_IDLE;
            S_IDLE:   if (tick && pend_found)      state_nxt = S_SETUP;
            S_SETUP:  if (tick && phase == dur_m1) state_nxt = S_STROBE;
            S_STROBE: if (tick && phase == dur_m1) state_nxt = S_HOLD;
            S_HOLD:   if (tick && phase == dur_m1) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (state_nxt != state)
            phase_nxt = '0;
    end

    always_comb begin
        busy_out     = (state != S_IDLE);
        a_nxt        = A_out;
        wr_nxt       = WR_out;
        sel_nxt      = sel;
        gain_lat_nxt = gain_lat;
        applied_nxt  = applied_out;
        rr_nxt       = rr_ptr;
        // A refresh clear lands first so a write completing on the same tick stays valid.
        valid_nxt    = refresh_hit ? '0 : valid_out;
        if (state == S_IDLE && state_nxt == S_SETUP) begin
            sel_nxt = pend_ch;
            for (int i = 0; i < N_CH; i++)
                if (CW'(i) == pend_ch)
                    gain_lat_nxt = gain_in[i*GAIN_W +: GAIN_W];
            a_nxt = gain_lat_nxt;
        end
        if (state == S_SETUP && state_nxt == S_STROBE)
            for (int i = 0; i < N_CH; i++)
                wr_nxt[i] = (CW'(i) == sel);
        if (state == S_STROBE && state_nxt == S_HOLD) begin
            wr_nxt = '0;
            for (int i = 0; i < N_CH; i++)
                if (CW'(i) == sel) begin
                    applied_nxt[i*GAIN_W +: GAIN_W] = gain_lat;
                    valid_nxt[i] = 1'b1;
                end
        end
        if (state == S_HOLD && state_nxt == S_IDLE) begin
            a_nxt  = '0;
            rr_nxt = (sel == CW'(N_CH - 1)) ? '0 : sel + 1'b1;
        end
        if (state > S_HOLD) begin
            a_nxt  = '0;
            wr_nxt = '0;
        end
    end

endmodule
